// File: rtl/psg_pkg.sv
// Shared definitions for the PSG register-write scheduler.
// Holds the scheduler FSM state type, the {addr,data} write record, the
// {bdir,bc1} bus-cycle encodings and the envelope-shape register address.
package psg_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLatch = 2'd1,
        StWrite = 2'd2,
        StGap   = 2'd3
    } psg_state_e;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } psg_wr_t;

    localparam int unsigned WR_W = 12;

    // {bdir, bc1} encodings
    localparam logic [1:0] BUS_INACTIVE = 2'b00;
    localparam logic [1:0] BUS_LATCH    = 2'b11;
    localparam logic [1:0] BUS_WRITE    = 2'b10;

    // Writing the envelope shape register retriggers the envelope, so it is
    // never suppressed as redundant.
    localparam logic [3:0] ENV_SHAPE_ADDR = 4'd13;

endpackage

// File: rtl/psg_write_fifo.sv
// Host write FIFO for the PSG scheduler.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata    - write one {addr,data} entry (ignored when full)
//   pop, rdata     - remove the head entry (ignored when empty); rdata shows head
//   full, empty    - occupancy flags from extended-pointer comparison
module psg_write_fifo
    import psg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [WR_W-1:0] wdata,
    input  logic            pop,
    output logic [WR_W-1:0] rdata,
    output logic            full,
    output logic            empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty; wraps mod 2*DEPTH.
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [WR_W-1:0] mem_q [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/psg_write_sched.sv
// PSG register-write scheduler: merges buffered host writes and unbuffered
// player writes onto the AY-3-8913 register bus (LATCH address, WRITE data,
// one inactive GAP cycle), round-robin when both sources are requesting.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   host_valid/ready/addr/data - host write request, buffered in a FIFO
//   play_valid/ready/addr/data - player write request, ready pulses on grant
//   bdir, bc1, da_out          - registered PSG bus outputs
//   busy                       - FSM active or FIFO non-empty
//   shadow_addr, shadow_data   - shadow register read port (shadow build only)
// Build option: define PSG_SCHED_SHADOW_EN to keep a 16x8 shadow copy of the
// PSG registers and drop writes that would not change a register (except the
// envelope shape register).
module psg_write_sched
    import psg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_data,
    input  logic       play_valid,
    output logic       play_ready,
    input  logic [3:0] play_addr,
    input  logic [7:0] play_data,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] da_out,
`ifdef PSG_SCHED_SHADOW_EN
    input  logic [3:0] shadow_addr,
    output logic [7:0] shadow_data,
`endif
    output logic       busy
);

    localparam logic [3:0] PhaseLoad = 4'(PHASE_CYCLES - 1);

    psg_state_e      state_q, state_d;
    psg_wr_t         cap_q, cap_d;
    logic [3:0]      phase_q, phase_d;
    logic            last_play_q, last_play_d;
    logic            rst_done_q;
    logic [1:0]      bus_q, bus_d;
    logic [7:0]      da_q, da_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic [WR_W-1:0] fifo_rdata;
    psg_wr_t         fifo_head;
    logic            req_host;
    logic            req_play;
    logic            grant_host;
    logic            grant_play;
    psg_wr_t         grant_wr;
    logic            drop;

    // ---------------------------------------------------------------------
    // Host FIFO
    // ---------------------------------------------------------------------
    // rst_done_q holds ready low for the cycle right after a reset edge.
    assign host_ready = !fifo_full && rst_done_q;

    psg_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host_valid && host_ready),
        .wdata ({host_addr, host_data}),
        .pop   (grant_host),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_head = psg_wr_t'(fifo_rdata);

    // ---------------------------------------------------------------------
    // Arbitration (only in IDLE); last_play_q=1 means the player won last
    // ---------------------------------------------------------------------
    always_comb begin
        req_host   = (state_q == StIdle) && rst_done_q && !fifo_empty;
        req_play   = (state_q == StIdle) && rst_done_q && play_valid;
        grant_host = req_host && (!req_play || last_play_q);
        grant_play = req_play && !grant_host;
        grant_wr   = fifo_head;
        if (!grant_host) begin
            grant_wr.addr = play_addr;
            grant_wr.data = play_data;
        end
    end

    assign play_ready = grant_play;
    assign busy       = (state_q != StIdle) || !fifo_empty;

`ifdef PSG_SCHED_SHADOW_EN
    logic [7:0] shadow_q [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if (state_q == StLatch && state_d == StWrite) begin
            shadow_q[cap_q.addr] <= cap_q.data;
        end
    end

    assign drop        = (shadow_q[grant_wr.addr] == grant_wr.data) &&
                         (grant_wr.addr != ENV_SHAPE_ADDR);
    assign shadow_data = shadow_q[shadow_addr];
`else
    assign drop = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cap_q       <= '0;
            phase_q     <= 4'd0;
            last_play_q <= 1'b1;
            rst_done_q  <= 1'b0;
            bus_q       <= BUS_INACTIVE;
            da_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            phase_q     <= phase_d;
            last_play_q <= last_play_d;
            rst_done_q  <= 1'b1;
            bus_q       <= bus_d;
            da_q        <= da_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        phase_d     = phase_q;
        last_play_d = last_play_q;
        case (state_q)
            StIdle: begin
                if (grant_host || grant_play) begin
                    last_play_d = grant_play;
                    // A dropped write still consumes its grant but never leaves IDLE.
                    if (!drop) begin
                        cap_d   = grant_wr;
                        state_d = StLatch;
                        phase_d = PhaseLoad;
                    end
                end
            end
            StLatch: begin
                if (phase_q == 4'd0) begin
                    state_d = StWrite;
                    phase_d = PhaseLoad;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            StWrite: begin
                if (phase_q == 4'd0) begin
                    state_d = StGap;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs, decoded from the next state so the bus pins are flops
    // ---------------------------------------------------------------------
    always_comb begin
        bus_d = BUS_INACTIVE;
        da_d  = 8'h00;
        case (state_d)
            StLatch: begin
                bus_d = BUS_LATCH;
                da_d  = {4'h0, cap_d.addr};
            end
            StWrite: begin
                bus_d = BUS_WRITE;
                da_d  = cap_d.data;
            end
            default: begin
                bus_d = BUS_INACTIVE;
                da_d  = 8'h00;
            end
        endcase
    end

    assign bdir   = bus_q[1];
    assign bc1    = bus_q[0];
    assign da_out = da_q;

endmodule

// File: tb/tb_psg_write_sched.sv
// Self-checking bench for psg_write_sched: a transaction-level reference model
// predicts grants, ready handshakes and bus transactions; a monitor process
// checks the bus against the queue of expected transactions.
module tb_psg_write_sched;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PC         = 2;
    localparam int          TXN_LEN    = 2 * PC + 2;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         start;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_data = 8'h00;
    logic       play_valid = 1'b0;
    logic       play_ready;
    logic [3:0] play_addr = 4'h0;
    logic [7:0] play_data = 8'h00;
    logic       bdir;
    logic       bc1;
    logic [7:0] da_out;
    logic       busy;
`ifdef PSG_SCHED_SHADOW_EN
    logic [3:0] shadow_addr = 4'h0;
    logic [7:0] shadow_data;
`endif

    psg_write_sched #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PHASE_CYCLES (PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .play_valid  (play_valid),
        .play_ready  (play_ready),
        .play_addr   (play_addr),
        .play_data   (play_data),
        .bdir        (bdir),
        .bc1         (bc1),
        .da_out      (da_out),
`ifdef PSG_SCHED_SHADOW_EN
        .shadow_addr (shadow_addr),
        .shadow_data (shadow_data),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic wr_t mk(input int a, input int d);
        wr_t w;
        w.addr = 4'(a);
        w.data = 8'(d);
        return w;
    endfunction

    // Reference model state
    wr_t        hq[$];
    txn_t       exp_q[$];
    bit         last_play = 1'b1;
    int         free_at = 0;
    int         last_g = -1;
    bit         rst_done = 1'b0;
    bit         prev_rst = 1'b0;
    logic [7:0] m_shadow [16];

    // Driver state
    wr_t host_src[$];
    wr_t play_src[$];
    int  h_rate = 100;
    int  p_rate = 100;
    bit  h_acc = 1'b0;
    bit  p_acc = 1'b0;
    bit  drv_reset = 1'b1;
    int  last_acc_cyc = 0;
    int  seen_full = 0;

    // Monitor state
    bit         active = 1'b0;
    txn_t       cur;
    int         n_lat = 0;
    int         last_latch_cyc = 0;
    logic [3:0] seen_addr[$];
    int         addr_cnt [16];

    // One clock cycle: drive inputs at negedge, evaluate the model at +1.
    task automatic step();
        int  c;
        bit  exp_hr, exp_pr, exp_busy, hreq, preq, gh, drop;
        wr_t w;
        txn_t t;
        @(negedge clk);
        reset = drv_reset;
        if (h_acc) host_valid = 1'b0;
        if (p_acc) play_valid = 1'b0;
        h_acc = 1'b0;
        p_acc = 1'b0;
        if (!host_valid && host_src.size() > 0 && $urandom_range(0, 99) < h_rate) begin
            w = host_src.pop_front();
            host_addr  = w.addr;
            host_data  = w.data;
            host_valid = 1'b1;
        end
        if (!play_valid && play_src.size() > 0 && $urandom_range(0, 99) < p_rate) begin
            w = play_src.pop_front();
            play_addr  = w.addr;
            play_data  = w.data;
            play_valid = 1'b1;
        end
        #1;
        c = cyc;
        if (reset) begin
            if (prev_rst) begin
                check("rst_host_ready", host_ready, 0);
                check("rst_play_ready", play_ready, 0);
                check("rst_busy", busy, 0);
            end
            hq.delete();
            exp_q.delete();
            last_play = 1'b1;
            free_at   = 0;
            last_g    = -1;
            rst_done  = 1'b0;
            for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
            h_acc    = host_valid;
            p_acc    = play_valid;
            prev_rst = 1'b1;
        end else begin
            exp_hr   = rst_done && (hq.size() < FIFO_DEPTH);
            exp_busy = (c < free_at && c > last_g) || (hq.size() > 0);
            exp_pr   = 1'b0;
            if (rst_done && c >= free_at) begin
                hreq = hq.size() > 0;
                preq = play_valid;
                if (hreq || preq) begin
                    gh = hreq && (!preq || last_play);
                    if (gh) begin
                        w = hq.pop_front();
                    end else begin
                        w.addr = play_addr;
                        w.data = play_data;
                        exp_pr = 1'b1;
                    end
                    last_play = !gh;
                    last_g    = c;
                    drop      = 1'b0;
`ifdef PSG_SCHED_SHADOW_EN
                    drop = (m_shadow[w.addr] == w.data) && (w.addr != 4'd13);
                    if (!drop) m_shadow[w.addr] = w.data;
`endif
                    if (drop) begin
                        free_at = c + 1;
                    end else begin
                        free_at = c + TXN_LEN;
                        t.addr  = w.addr;
                        t.data  = w.data;
                        t.start = c + 1;
                        exp_q.push_back(t);
                    end
                end
            end
            check("host_ready", host_ready, exp_hr);
            check("play_ready", play_ready, exp_pr);
            check("busy", busy, exp_busy);
            if (host_valid && !host_ready) seen_full++;
            h_acc = host_valid && exp_hr;
            if (h_acc) begin
                w.addr = host_addr;
                w.data = host_data;
                hq.push_back(w);
                last_acc_cyc = c;
            end
            p_acc    = exp_pr;
            rst_done = 1'b1;
            prev_rst = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 300 && !(host_src.size() == 0 && play_src.size() == 0 && !host_valid &&
                            !play_valid && hq.size() == 0 && cyc >= free_at &&
                            exp_q.size() == 0)) begin
            step();
            k++;
        end
        check("drain_in_time", (k < 300) ? 1 : 0, 1);
        run(2);
    endtask

    // Bus monitor: compares each transaction against the expected queue.
    initial begin
        int o;
        for (int i = 0; i < 16; i++) addr_cnt[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    if ({bdir, bc1} === 2'b11) begin
                        n_lat++;
                        last_latch_cyc = cyc;
                        seen_addr.push_back(da_out[3:0]);
                        addr_cnt[da_out[3:0]]++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_txn", 1, 0);
                        end else begin
                            cur    = exp_q.pop_front();
                            active = 1'b1;
                            check("latch_start_cycle", cyc, cur.start);
                        end
                    end else begin
                        check("idle_bus", {bdir, bc1}, 2'b00);
                        check("idle_da", da_out, 8'h00);
                        if (exp_q.size() > 0 && exp_q[0].start < cyc) begin
                            check("missing_txn", cyc, exp_q[0].start);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (active) begin
                    o = cyc - cur.start;
                    if (o < int'(PC)) begin
                        check("latch_bus", {bdir, bc1}, 2'b11);
                        check("latch_da", da_out, {4'h0, cur.addr});
                    end else if (o < int'(2 * PC)) begin
                        check("write_bus", {bdir, bc1}, 2'b10);
                        check("write_da", da_out, cur.data);
                    end else begin
                        check("gap_bus", {bdir, bc1}, 2'b00);
                        check("gap_da", da_out, 8'h00);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int sidx, lat0, k, nseen;
        wr_t w;

        // Reset with a player request pending: nothing may be granted.
        play_valid = 1'b1;
        play_addr  = 4'h9;
        play_data  = 8'hAA;
        drv_reset  = 1'b1;
        run(4);
        drv_reset = 1'b0;
        run(2);

        // Both sources continuously: host wins the first tie, then alternate.
        sidx = seen_addr.size();
        for (int i = 0; i < 4; i++) begin
            host_src.push_back(mk(i + 1, 8'h10 + i));
            play_src.push_back(mk(i + 8, 8'h80 + i));
        end
        p_rate = 0;
        run(1);
        p_rate = 100;
        drain();
        nseen = seen_addr.size() - sidx;
        check("rr_count", nseen, 8);
        for (int i = 0; i < 8 && i < nseen; i++) begin
            check("rr_order", (seen_addr[sidx + i] >= 4'd8) ? 1 : 0, i % 2);
        end

        // Single host write and its latency.
        host_src.push_back(mk(7, 8'h38));
        drain();
        check("single_latency", last_latch_cyc - last_acc_cyc, 2);

        // Back-to-back host writes while the FSM is busy with a player write.
        play_src.push_back(mk(12, 8'h5A));
        for (int i = 0; i < 5; i++) host_src.push_back(mk(i + 1, 8'h20 + i));
        seen_full = 0;
        drain();
        check("fifo_full_seen", (seen_full > 0) ? 1 : 0, 1);

        // Reset in the first WRITE cycle with entries queued behind it.
        for (int i = 0; i < 4; i++) host_src.push_back(mk(i + 2, 8'hC0 + i));
        k = 0;
        while (k < 40 && !(last_g >= 0 && cyc + 1 == last_g + int'(PC) + 1 && free_at > cyc + 1)) begin
            step();
            k++;
        end
        check("found_write_phase", (k < 40) ? 1 : 0, 1);
        drv_reset = 1'b1;
        run(1);
        drv_reset = 1'b0;
        lat0 = n_lat;
        run(15);
        check("no_txn_after_reset", n_lat - lat0, 0);

        // Redundant-write suppression (register 13 always issued).
        for (int i = 0; i < 16; i++) addr_cnt[i] = 0;
        host_src.push_back(mk(0, 8'h55));
        host_src.push_back(mk(0, 8'h55));
        host_src.push_back(mk(13, 8'h0E));
        host_src.push_back(mk(13, 8'h0E));
        drain();
`ifdef PSG_SCHED_SHADOW_EN
        check("shadow_reg0_txns", addr_cnt[0], 1);
        shadow_addr = 4'd0;
        #1;
        check("shadow_data0", shadow_data, 8'h55);
`else
        check("reg0_txns", addr_cnt[0], 2);
`endif
        check("reg13_txns", addr_cnt[13], 2);

        // Randomized traffic from both sources.
        h_rate = 60;
        p_rate = 40;
        for (int n = 0; n < 400; n++) begin
            if (host_src.size() < 2) begin
                w.addr = 4'($urandom_range(0, 15));
                w.data = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 2));
                host_src.push_back(w);
            end
            if (play_src.size() < 1) begin
                w.addr = 4'($urandom_range(0, 15));
                w.data = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 2));
                play_src.push_back(w);
            end
            step();
        end
        h_rate = 100;
        p_rate = 100;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
